// File: rtl/branch_imm_encoder.sv
// RV32I B-type encoder: packs (target - pc) into the split branch immediate, rejecting bad funct3/misaligned offsets.
// Optional IMM_RANGE_CHECK_EN: also rejects offsets outside the signed 13-bit branch range (code 11).
module branch_imm_encoder #(
    parameter int unsigned CNT_W  = 16,
    parameter logic [6:0]  OPCODE = 7'b1100011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_target,
    input  logic [2:0]       in_funct3,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_addr,
    output logic             err_valid,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       target_q, target_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [31:0]       out_addr_q, out_addr_d;
    logic              err_valid_q, err_valid_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;

    logic [31:0]       off;
    logic [1:0]        chk_code;
    logic [31:0]       enc_instr;
    logic              accept;

    assign off = target_q - pc_q;

    assign enc_instr = {off[12], off[10:5], rs2_q, rs1_q, funct3_q, off[4:1], off[11], OPCODE};

`ifndef IMM_RANGE_CHECK_EN
    // Without the range check the high offset bits are deliberately discarded.
    logic off_hi_unused;
    assign off_hi_unused = ^off[31:13];
`endif

    // First matching check wins; 00 means the request is encodable.
    always_comb begin
        chk_code = 2'b00;
        if (funct3_q == 3'b010 || funct3_q == 3'b011) begin
            chk_code = 2'b01;
        end else if (off[0]) begin
            chk_code = 2'b10;
`ifdef IMM_RANGE_CHECK_EN
        end else if (off[31:12] != {20{off[12]}}) begin
            chk_code = 2'b11;
`endif
        end
    end

    assign in_ready = (state_q == IDLE) || (state_q == OUT && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        target_d    = target_q;
        funct3_d    = funct3_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        out_count_d = out_count_q;

        if (accept) begin
            pc_d     = in_pc;
            target_d = in_target;
            funct3_d = in_funct3;
            rs1_d    = in_rs1;
            rs2_d    = in_rs2;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (chk_code != 2'b00) begin
                    err_valid_d = 1'b1;
                    err_code_d  = chk_code;
                    state_d     = IDLE;
                end else begin
                    out_instr_d = enc_instr;
                    out_addr_d  = pc_q;
                    state_d     = OUT;
                end
            end
            OUT: begin
                // A new request can only be taken here on the handshake cycle.
                if (out_ready) begin
                    out_count_d = out_count_q + CNT_W'(1);
                    state_d     = accept ? CALC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            target_q    <= '0;
            funct3_q    <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            funct3_q    <= funct3_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = (state_q == OUT);
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign out_count = out_count_q;

endmodule
